// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared CPU constants for the Ak-16b writeback path.
// Provides register file geometry, the zero-register index, the packed
// FIFO entry layout used by the load buffer, and a small helper that
// decides whether a destination actually produces a register write.
package wb_arbiter_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int ENTRY_W   = REG_IDX_W + DATA_W;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // r0 is hardwired to zero, so results aimed at it are consumed silently.
  function automatic logic writes_reg(input logic [REG_IDX_W-1:0] r);
    return r != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO buffering load results for writeback.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   head            entry at the read pointer
//   full, empty     occupancy flags from registered state
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and buffered load results into a single
// registered register-file write per cycle, with a starvation counter that
// forces loads through and a busy scoreboard of outstanding loads.
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   ld_valid/ld_ready/ld_rd/ld_data       load result handshake (buffered)
//   mark_valid/mark_rd                issue stage marks a load destination
//   reg_write/rd/rd_data              registered write port
//   busy                              per-register outstanding-load bits
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 mark_valid,
  input  logic [REG_IDX_W-1:0] mark_rd,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] rd,
  output logic [DATA_W-1:0]    rd_data,
  output logic [NUM_REGS-1:0]  busy
);

  localparam int                  STARVE_W     = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  load_pri;
  logic                  alu_take;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [NUM_REGS-1:0]   busy_next;

  assign push_entry = '{rd: ld_rd, data: ld_data};

  // Handshakes depend only on registered state and rst, so a pop never
  // opens room for a push in the same cycle.
  assign load_pri  = !fifo_empty && (starve_cnt == STARVE_LIMIT);
  assign ld_ready  = rst && !fifo_full;
  assign alu_ready = rst && !load_pri;
  assign push      = ld_valid && ld_ready;
  assign alu_take  = alu_valid && alu_ready;
  assign pop       = rst && !fifo_empty && (load_pri || !alu_valid);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output write port: a pop has priority because pop already encodes the
  // load_pri / idle-ALU decision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else if (pop) begin
      reg_write <= writes_reg(head_entry.rd);
      rd        <= head_entry.rd;
      rd_data   <= head_entry.data;
    end else if (alu_take) begin
      reg_write <= writes_reg(alu_rd);
      rd        <= alu_rd;
      rd_data   <= alu_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Counts ALU wins while a load is waiting; any pop or an empty FIFO
  // restarts the count.
  always_ff @(posedge clk) begin
    if (!rst || pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (alu_take && (starve_cnt != STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Clear is applied before set so a same-edge mark of the popped
  // register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_entry.rd] = 1'b0;
    if (mark_valid) busy_next[mark_rd] = 1'b1;
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (DEPTH=2,
// STARVE_MAX=4). Inputs change 1ns after each rising edge; outputs are
// checked 1ns after that, well away from the next edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [3:0]  ld_rd;
  logic [15:0] ld_data;
  logic        mark_valid;
  logic [3:0]  mark_rd;
  logic        reg_write;
  logic [3:0]  rd;
  logic [15:0] rd_data;
  logic [15:0] busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .reg_write  (reg_write),
    .rd         (rd),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = 4'd0;
    alu_data   = 16'h0000;
    ld_valid   = 1'b0;
    ld_rd      = 4'd0;
    ld_data    = 16'h0000;
    mark_valid = 1'b0;
    mark_rd    = 4'd0;
  endtask

  task automatic settle();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst       = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 4'd5;
    alu_data  = 16'hDEAD;
    ld_valid  = 1'b1;
    ld_rd     = 4'd5;
    ld_data   = 16'hBEEF;
    tick();
    tick();
    tests_run++;
    if ({reg_write, rd, rd_data, busy} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got we=%b rd=%h data=%h busy=%h expected all zero",
               reg_write, rd, rd_data, busy);
    end
    tests_run++;
    if ({alu_ready, ld_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got alu_ready=%b ld_ready=%b expected 0 0", alu_ready, ld_ready);
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({alu_ready, ld_ready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL release_ready: got alu_ready=%b ld_ready=%b expected 1 1", alu_ready, ld_ready);
    end
    tick();
    tick();
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_no_write: got reg_write=%b expected 0", reg_write);
    end
  endtask

  task automatic test_alu_stream();
    logic [3:0]  rds  [3] = '{4'd3, 4'd4, 4'd5};
    logic [15:0] dats [3] = '{16'h0011, 16'h0022, 16'h0033};
    settle();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c < 3) begin
        alu_valid = 1'b1;
        alu_rd    = rds[c];
        alu_data  = dats[c];
      end
      #1;
      tests_run++;
      if (alu_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL alu_stream_ready c%0d: got %b expected 1", c, alu_ready);
      end
      if (c > 0) begin
        tests_run++;
        if ({reg_write, rd, rd_data} !== {1'b1, rds[c-1], dats[c-1]}) begin
          tests_failed++;
          $display("[TB] FAIL alu_stream_write c%0d: got we=%b rd=%h data=%h expected 1 %h %h",
                   c, reg_write, rd, rd_data, rds[c-1], dats[c-1]);
        end
      end
      tick();
    end
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL alu_stream_end: got reg_write=%b expected 0", reg_write);
    end
  endtask

  task automatic test_single_load();
    settle();
    mark_valid = 1'b1;
    mark_rd    = 4'd7;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (busy !== 16'h0080) begin
      tests_failed++;
      $display("[TB] FAIL load_busy_set: got %h expected 0080", busy);
    end
    tick();
    ld_valid = 1'b1;
    ld_rd    = 4'd7;
    ld_data  = 16'hBEEF;
    #1;
    tests_run++;
    if (ld_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_ready: got %b expected 1", ld_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if ({reg_write, busy} !== {1'b0, 16'h0080}) begin
      tests_failed++;
      $display("[TB] FAIL load_cycle3: got we=%b busy=%h expected 0 0080", reg_write, busy);
    end
    tick();
    tests_run++;
    if ({reg_write, rd, rd_data, busy} !== {1'b1, 4'd7, 16'hBEEF, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL load_write: got we=%b rd=%h data=%h busy=%h expected 1 7 beef 0000",
               reg_write, rd, rd_data, busy);
    end
    tick();
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_after: got reg_write=%b expected 0", reg_write);
    end
  endtask

  task automatic test_starvation();
    bit          alu_v    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          alu_i    [8] = '{1, 2, 3, 4, 5, 6, 6, 6};
    bit          exp_ardy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit          exp_we   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  exp_rd   [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd6};
    logic [15:0] exp_dat  [8] = '{16'h0000, 16'hA001, 16'hA002, 16'hA003,
                                  16'hA004, 16'hA005, 16'h1234, 16'hA006};
    settle();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      alu_valid = alu_v[c];
      alu_rd    = 4'(alu_i[c]);
      alu_data  = 16'hA000 + 16'(alu_i[c]);
      ld_valid  = (c == 0);
      ld_rd     = 4'd9;
      ld_data   = 16'h1234;
      #1;
      tests_run++;
      if (alu_ready !== exp_ardy[c]) begin
        tests_failed++;
        $display("[TB] FAIL starve_alu_ready c%0d: got %b expected %b", c, alu_ready, exp_ardy[c]);
      end
      tests_run++;
      if (reg_write !== exp_we[c] || (exp_we[c] && {rd, rd_data} !== {exp_rd[c], exp_dat[c]})) begin
        tests_failed++;
        $display("[TB] FAIL starve_write c%0d: got we=%b rd=%h data=%h expected %b %h %h",
                 c, reg_write, rd, rd_data, exp_we[c], exp_rd[c], exp_dat[c]);
      end
      tick();
    end
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL starve_end: got reg_write=%b expected 0", reg_write);
    end
  endtask

  task automatic test_back_to_back();
    bit          alu_v    [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          alu_i    [10] = '{1, 2, 3, 4, 5, 6, 6, 0, 0, 0};
    bit          ld_v     [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          ld_i     [10] = '{10, 11, 12, 12, 12, 12, 12, 0, 0, 0};
    bit          exp_ldr  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit          exp_ardy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          exp_we   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  exp_rd   [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd10, 4'd6, 4'd11, 4'd12};
    logic [15:0] exp_dat  [10] = '{16'h0000, 16'hA001, 16'hA002, 16'hA003, 16'hA004,
                                   16'hA005, 16'hC00A, 16'hA006, 16'hC00B, 16'hC00C};
    settle();
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      alu_valid = alu_v[c];
      alu_rd    = 4'(alu_i[c]);
      alu_data  = 16'hA000 + 16'(alu_i[c]);
      ld_valid  = ld_v[c];
      ld_rd     = 4'(ld_i[c]);
      ld_data   = 16'hC000 + 16'(ld_i[c]);
      #1;
      tests_run++;
      if ({ld_ready, alu_ready} !== {exp_ldr[c], exp_ardy[c]}) begin
        tests_failed++;
        $display("[TB] FAIL bp_ready c%0d: got ld_ready=%b alu_ready=%b expected %b %b",
                 c, ld_ready, alu_ready, exp_ldr[c], exp_ardy[c]);
      end
      tests_run++;
      if (reg_write !== exp_we[c] || (exp_we[c] && {rd, rd_data} !== {exp_rd[c], exp_dat[c]})) begin
        tests_failed++;
        $display("[TB] FAIL bp_write c%0d: got we=%b rd=%h data=%h expected %b %h %h",
                 c, reg_write, rd, rd_data, exp_we[c], exp_rd[c], exp_dat[c]);
      end
      tick();
    end
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_end: got reg_write=%b expected 0", reg_write);
    end
  endtask

  task automatic test_r0_set_wins();
    settle();
    mark_valid = 1'b1;
    mark_rd    = 4'd0;
    alu_valid  = 1'b1;
    alu_rd     = 4'd0;
    alu_data   = 16'h7777;
    #1;
    tests_run++;
    if (alu_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL r0_alu_ready: got %b expected 1", alu_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if ({reg_write, rd, rd_data, busy} !== {1'b0, 4'd0, 16'h7777, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL r0_alu: got we=%b rd=%h data=%h busy=%h expected 0 0 7777 0000",
               reg_write, rd, rd_data, busy);
    end
    ld_valid = 1'b1;
    ld_rd    = 4'd0;
    ld_data  = 16'h5555;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if ({reg_write, rd, rd_data, ld_ready} !== {1'b0, 4'd0, 16'h5555, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL r0_load: got we=%b rd=%h data=%h ld_ready=%b expected 0 0 5555 1",
               reg_write, rd, rd_data, ld_ready);
    end
    mark_valid = 1'b1;
    mark_rd    = 4'd6;
    tick();
    idle_inputs();
    ld_valid = 1'b1;
    ld_rd    = 4'd6;
    ld_data  = 16'h6666;
    tick();
    idle_inputs();
    mark_valid = 1'b1;
    mark_rd    = 4'd6;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if ({reg_write, rd, rd_data, busy} !== {1'b1, 4'd6, 16'h6666, 16'h0040}) begin
      tests_failed++;
      $display("[TB] FAIL set_wins: got we=%b rd=%h data=%h busy=%h expected 1 6 6666 0040",
               reg_write, rd, rd_data, busy);
    end
    ld_valid = 1'b1;
    ld_rd    = 4'd6;
    ld_data  = 16'h6667;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if ({reg_write, rd_data, busy} !== {1'b1, 16'h6667, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL busy_clear6: got we=%b data=%h busy=%h expected 1 6667 0000",
               reg_write, rd_data, busy);
    end
  endtask

  task automatic test_reset_mid();
    settle();
    mark_valid = 1'b1;
    mark_rd    = 4'd8;
    alu_valid  = 1'b1;
    alu_rd     = 4'd1;
    alu_data   = 16'hA101;
    ld_valid   = 1'b1;
    ld_rd      = 4'd8;
    ld_data    = 16'h8888;
    tick();
    mark_rd  = 4'd9;
    alu_rd   = 4'd2;
    alu_data = 16'hA102;
    ld_rd    = 4'd9;
    ld_data  = 16'h9999;
    tick();
    mark_valid = 1'b0;
    ld_valid   = 1'b0;
    alu_rd     = 4'd3;
    alu_data   = 16'hA103;
    #1;
    tests_run++;
    if ({busy, ld_ready} !== {16'h0300, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL mid_pre: got busy=%h ld_ready=%b expected 0300 0", busy, ld_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (alu_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_alu_gate: got alu_ready=%b expected 0", alu_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if ({reg_write, rd, rd_data, busy} !== 37'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got we=%b rd=%h data=%h busy=%h expected all zero",
               reg_write, rd, rd_data, busy);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({ld_ready, reg_write} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL mid_release: got ld_ready=%b we=%b expected 1 0", ld_ready, reg_write);
    end
    tick();
    tests_run++;
    if ({reg_write, busy} !== {1'b0, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL mid_no_stale: got we=%b busy=%h expected 0 0000", reg_write, busy);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_stream();
    test_single_load();
    test_starvation();
    test_back_to_back();
    test_r0_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory side of the Ak-16b core and the register file write port. It merges single-cycle ALU results and variable-latency load results into one registered write per cycle (`reg_write`/`rd`/`rd_data`). Load results are buffered in a small FIFO, and a starvation counter guarantees that loads drain. The block also keeps a per-register busy scoreboard of outstanding loads for the issue stage.

## Interface
Parameters:
- `DEPTH`, 2: load FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 4: consecutive ALU wins over a non-empty FIFO before loads get priority

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; one clock, synchronous, active-low (0 = reset)
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  4  ALU destination register
- `alu_data`  in  16  ALU result
- `ld_valid`  in  1  load result present
- `ld_ready`  out  1  load result accepted this cycle
- `ld_rd`  in  4  load destination register
- `ld_data`  in  16  load data
- `mark_valid`  in  1  issue stage dispatched a load
- `mark_rd`  in  4  destination of that load
- `reg_write`  out  1  register file write enable (registered)
- `rd`  out  4  write address (registered)
- `rd_data`  out  16  write data (registered)
- `busy`  out  16  bit i = register i has an outstanding load; bit 0 always 0

## Operation
- **Load side**
  - `ld_ready = !full`.
  - A transfer happens when `ld_valid && ld_ready` at a clock edge. It pushes {`ld_rd`, `ld_data`} into the FIFO.
  - Loads never bypass the FIFO.
- **Selection each cycle:** `load_pri = !empty && (starve_cnt == STARVE_MAX)`.
  - **`load_pri` = 1:**
    - `alu_ready` = 0.
    - The FIFO head is popped into the output registers.
    - The ALU must hold `alu_valid`, `alu_rd` and `alu_data`.
  - **Else, if `alu_valid`:**
    - `alu_ready` = 1.
    - The ALU result goes to the output registers.
    - If the FIFO is non-empty, `starve_cnt` increments, saturating at `STARVE_MAX`.
  - **Else, if FIFO non-empty:** the head is popped into the output registers.
  - **Else:** `reg_write` is loaded with 0.
  - **Otherwise:** `alu_ready` = 1 whenever it is not forced to 0 above.
- **Starvation counter:** `starve_cnt` resets to 0 on any pop, and whenever the FIFO is empty.
- **Destination r0:** a selected entry with destination 0 is consumed (popped or accepted) but drives `reg_write` = 0. `rd` and `rd_data` still update.
- **Scoreboard**
  - `mark_valid` sets `busy[mark_rd]` at the edge, ignored when `mark_rd` = 0.
  - A FIFO pop clears `busy[head_rd]` at the same edge.
  - If set and clear hit the same register at the same edge, set wins.
  - ALU writes never touch `busy`.
- **Full-FIFO push and pop:** when the FIFO is full, a pop in the same cycle does not enable a push (`ld_ready` depends only on registered state).
- **FIFO pointers:** read and write pointers wrap modulo `DEPTH`. Occupancy is tracked with a count of width clog2(DEPTH)+1.

## Timing
- **ALU latency:** `alu_valid && alu_ready` in cycle N gives `reg_write` = 1 in cycle N+1. The register file writes at the end of N+1.
- **Load latency:** a load accepted in cycle N is at minimum written with `reg_write` = 1 in cycle N+2.
- **Worst-case load wait:** a load waits at most `STARVE_MAX`+1 cycles behind continuous ALU traffic per FIFO entry ahead of it.
- **Busy clear:** `busy` is registered. A bit clears in the same cycle that its write appears on `reg_write`.
- **While `rst` = 0, after the edge:**
  - `reg_write` = 0, `rd` = 0, `rd_data` = 0, `busy` = 0
  - FIFO empty, `starve_cnt` = 0
  - `ld_ready` = 0 and `alu_ready` = 0, both gated by `rst`
- **Reset mid-operation:** buffered loads and busy bits are discarded. Upstream must reissue.

## Structure
- **Shared CPU package:** register count (16), register index width (4), data width (16), and the localparam for the zero register.
- **Sub-module `wb_fifo`:** parameterised by `DEPTH` and width 20. It provides push, pop, head, full and empty. The arbiter, scoreboard and output registers live in `wb_arbiter`.

## Test plan
- **ALU stream:** `alu_valid` for 3 cycles with rd=3,4,5 and data 0x0011/0x0022/0x0033, FIFO empty -> `reg_write` high for 3 cycles starting one cycle later, with matching rd/data and `alu_ready` constantly 1.
- **Single load with scoreboard:** `mark_valid` rd=7 in cycle 0, load rd=7 data 0xBEEF in cycle 2, no ALU -> `busy[7]` = 1 from cycle 1, write 0xBEEF to r7 in cycle 4, `busy[7]` = 0 in cycle 4.
- **Starvation:** continuous ALU traffic, then a load rd=9 data 0x1234 -> 4 ALU writes, then `alu_ready` = 0 for one cycle and r9 is written, then ALU resumes with the held result intact.
- **Backpressure:** continuous ALU traffic and 3 back-to-back loads with `DEPTH` = 2 -> `ld_ready` drops after 2 accepts. The third load is accepted only after a pop, and all three are written in order.
- **r0 and set-wins:** a load to r0 is consumed with `reg_write` = 0. A pop of rd=6 in the same cycle as `mark_valid` rd=6 leaves `busy[6]` = 1.
- **Reset mid-operation:** assert `rst` = 0 with 2 loads buffered and `busy` = 0x0300 -> next cycle all outputs are 0. After release, the FIFO is empty and no stale write appears.
